// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding buffer so back-to-back
// frames leave the serial line with no idle gap between them.
//   state    | meaning
//   S_IDLE   | line idle high, waiting for a byte
//   S_START  | start bit (low)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when PARITY_EN=1)
//   S_STOP   | stop bit(s), high
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_loaded,
  input  logic [7:0] data_byte,
  output logic       ready,
  output logic       uart_out,
  output logic       lineactive,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   ready_q, uart_out_q, uart_out_d;
  logic                   lineactive_q, done_q, done_d;
  logic                   accept, bit_end, take_direct;

  // upper byte bits are deliberately dropped for narrow frames
  logic unused_bits;
  assign unused_bits = ^data_byte;

  assign accept  = data_loaded & ready_q;
  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    take_direct  = 1'b0;
    uart_out_d   = 1'b1;

    if (state_q != S_IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          take_direct = 1'b1;
          state_d     = S_START;
          clk_cnt_d   = '0;
          bit_cnt_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            // chain straight into the next start bit when a byte is waiting
            if (hold_valid_q) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
              state_d      = S_START;
            end else if (accept) begin
              take_direct = 1'b1;
              state_d     = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_direct) begin
      shift_d = data_byte[DATA_BITS-1:0];
    end else if (accept) begin
      hold_d       = data_byte[DATA_BITS-1:0];
      hold_valid_d = 1'b1;
    end

    // line level is computed from next-state so the output register lines up
    case (state_d)
      S_START:  uart_out_d = 1'b0;
      S_DATA:   uart_out_d = shift_d[bit_cnt_d];
      S_PARITY: uart_out_d = (^shift_d) ^ (PARITY_ODD != 0);
      default:  uart_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      uart_out_q   <= 1'b1;
      lineactive_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ~hold_valid_d;
      uart_out_q   <= uart_out_d;
      lineactive_q <= (state_d != S_IDLE);
      done_q       <= done_d;
    end
  end

  assign ready      = ready_q;
  assign uart_out   = uart_out_q;
  assign lineactive = lineactive_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations driven side by side, each compared
// every cycle against a frame-queue model of the serial line.
module tb_uart_tx_cfg;

  localparam int CPB  = 8;
  localparam int NDUT = 3;
  localparam int DB_C [NDUT] = '{8, 7, 8};
  localparam int PE_C [NDUT] = '{0, 1, 1};
  localparam int PO_C [NDUT] = '{0, 0, 1};
  localparam int SB_C [NDUT] = '{1, 1, 2};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDUT-1:0] dl = '0;
  logic [7:0]      db [NDUT];
  logic [NDUT-1:0] rdy, line, act, dn;

  always #5 clk = ~clk;

  uart_tx_cfg u_def (
    .clk(clk), .rst_n(rst_n), .data_loaded(dl[0]), .data_byte(db[0]),
    .ready(rdy[0]), .uart_out(line[0]), .lineactive(act[0]), .done(dn[0])
  );

  uart_tx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u_par7 (
    .clk(clk), .rst_n(rst_n), .data_loaded(dl[1]), .data_byte(db[1]),
    .ready(rdy[1]), .uart_out(line[1]), .lineactive(act[1]), .done(dn[1])
  );

  uart_tx_cfg #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd2 (
    .clk(clk), .rst_n(rst_n), .data_loaded(dl[2]), .data_byte(db[2]),
    .ready(rdy[2]), .uart_out(line[2]), .lineactive(act[2]), .done(dn[2])
  );

  // model: remaining line levels of the current frame, one entry per cycle
  bit       cur_q [NDUT][$];
  bit       held_v [NDUT];
  bit [7:0] held_b [NDUT];
  bit       done_m [NDUT];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
  endtask

  task automatic load_frame(input int d, input bit [7:0] b);
    bit p;
    p = 1'b0;
    repeat (CPB) cur_q[d].push_back(1'b0);
    for (int i = 0; i < DB_C[d]; i++) begin
      p = p ^ b[i];
      repeat (CPB) cur_q[d].push_back(b[i]);
    end
    if (PE_C[d] != 0) begin
      if (PO_C[d] != 0) p = ~p;
      repeat (CPB) cur_q[d].push_back(p);
    end
    repeat (SB_C[d] * CPB) cur_q[d].push_back(1'b1);
  endtask

  // compare the current cycle mid-period, then advance the model by one cycle
  task automatic tick();
    bit acc;
    bit e_act;
    bit e_line;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      e_act  = (cur_q[d].size() != 0);
      e_line = e_act ? cur_q[d][0] : 1'b1;
      chk($sformatf("line[%0d]", d),   int'(line[d]), int'(e_line));
      chk($sformatf("active[%0d]", d), int'(act[d]),  int'(e_act));
      chk($sformatf("ready[%0d]", d),  int'(rdy[d]),  int'(!held_v[d]));
      chk($sformatf("done[%0d]", d),   int'(dn[d]),   int'(done_m[d]));

      acc = dl[d] && !held_v[d];
      done_m[d] = 1'b0;
      if (cur_q[d].size() != 0) begin
        void'(cur_q[d].pop_front());
        if (cur_q[d].size() == 0) begin
          done_m[d] = 1'b1;
          if (held_v[d]) begin
            load_frame(d, held_b[d]);
            held_v[d] = 1'b0;
          end else if (acc) begin
            load_frame(d, db[d]);
            acc = 1'b0;
          end
        end
        if (acc) begin
          held_v[d] = 1'b1;
          held_b[d] = db[d];
        end
      end else if (acc) begin
        load_frame(d, db[d]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_line[%0d]", d),   int'(line[d]), 1);
      chk($sformatf("rst_active[%0d]", d), int'(act[d]),  0);
      chk($sformatf("rst_ready[%0d]", d),  int'(rdy[d]),  1);
      chk($sformatf("rst_done[%0d]", d),   int'(dn[d]),   0);
      cur_q[d].delete();
      held_v[d] = 1'b0;
      done_m[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int first_done;
    int a0, a1, a2;
    int n_done, d1, d2;

    for (int d = 0; d < NDUT; d++) db[d] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single frames: 0xA5 default, 0x03 7-bit even parity, 0x00 odd parity two stops
    dl = '1;
    db[0] = 8'hA5; db[1] = 8'h03; db[2] = 8'h00;
    tick();
    dl = '0;
    first_done = -1; a0 = 0; a1 = 0; a2 = 0;
    for (int i = 1; i <= 110; i++) begin
      if (dn[0] && first_done < 0) first_done = i;
      a0 += int'(act[0]);
      a1 += int'(act[1]);
      a2 += int'(act[2]);
      tick();
    end
    chk("done_latency_def", first_done, 81);
    chk("frame_len_def", a0, 80);
    chk("frame_len_par7", a1, 80);
    chk("frame_len_odd2", a2, 96);

    // chaining: 0x55, then 0x0F while busy, then a third request while full
    dl[0] = 1'b1; db[0] = 8'h55; tick();
    dl[0] = 1'b0; repeat (4) tick();
    dl[0] = 1'b1; db[0] = 8'h0F; tick();
    dl[0] = 1'b0; repeat (4) tick();
    dl[0] = 1'b1; db[0] = 8'hFF; tick();
    dl[0] = 1'b0;
    n_done = 0; d1 = 0; d2 = 0;
    for (int i = 11; i <= 220; i++) begin
      if (dn[0]) begin
        n_done++;
        if (n_done == 1) d1 = i;
        if (n_done == 2) d2 = i;
      end
      tick();
    end
    chk("chain_done_count", n_done, 2);
    chk("chain_done_gap", d2 - d1, 80);

    // reset during data bit 3, then a clean 0x81
    dl[0] = 1'b1; db[0] = 8'h5A; tick();
    dl[0] = 1'b0; repeat (35) tick();
    do_reset();
    dl[0] = 1'b1; db[0] = 8'h81; tick();
    dl[0] = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 100; i++) begin
      n_done += int'(dn[0]);
      tick();
    end
    chk("post_reset_done_count", n_done, 1);

    // random traffic; data_byte keeps changing every cycle
    repeat (3000) begin
      for (int d = 0; d < NDUT; d++) begin
        dl[d] = ($urandom_range(0, 15) == 0);
        db[d] = 8'($urandom);
      end
      tick();
    end
    dl = '0;
    repeat (250) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
